// File: rtl/lsu_mem_if.sv
// Load/store unit back end. Each core request becomes one word-aligned access on
// RAM port B. Store data is replicated across byte lanes and selected by byte
// enables. Load data is extracted and extended from the returned word.
// Misaligned and illegal requests get an error response and make no RAM access.
module lsu_mem_if #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  busy_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic                  accept;
  logic                  req_err;
  logic [3:0]            st_we;
  logic [31:0]           st_wdata;
  logic [31:0]           ld_data;
  logic [31:0]           ld_shb, ld_shh;

  // A new request can be taken whenever no RAM access is outstanding.
  assign req_ready_o  = (state_q != BUS);
  assign busy_o       = (state_q != IDLE);
  assign accept       = req_valid_i && req_ready_o;

  assign mem_valid_o  = mem_valid_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_we_o     = mem_we_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

  // Illegal size, or an access that does not fit naturally aligned in one word.
  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr_i[0];
      2'b10:   req_err = (req_addr_i[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  // Store formatting: replicate the data across lanes and pick lanes with byte enables.
  always_comb begin
    st_we    = 4'b1111;
    st_wdata = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        st_wdata = {4{req_wdata_i[7:0]}};
        st_we    = 4'b0001 << req_addr_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata_i[15:0]}};
        st_we    = req_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = req_wdata_i;
        st_we    = 4'b1111;
      end
    endcase
  end

  // Load formatting: shift the addressed lane down, then zero- or sign-extend.
  always_comb begin
    ld_shb  = mem_rdata_i >> {off_q, 3'b000};
    ld_shh  = mem_rdata_i >> {off_q[1], 4'b0000};
    ld_data = mem_rdata_i;
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'b0, ld_shb[7:0]}  : {{24{ld_shb[7]}}, ld_shb[7:0]};
      2'b01:   ld_data = uns_q ? {16'b0, ld_shh[15:0]} : {{16{ld_shh[15]}}, ld_shh[15:0]};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Next-state logic: accept in IDLE/RESP, wait for RAM completion in BUS, pulse response.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    we_d         = we_q;
    uns_d        = uns_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      BUS: begin
        // mem_ready_i is a completion pulse; request fields stay frozen until it arrives.
        if (mem_ready_i) begin
          mem_valid_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? 32'h0 : ld_data;
          state_d      = RESP;
        end
      end
      default: begin
        // IDLE and RESP behave alike; a stray mem_ready_i here is ignored.
        state_d = IDLE;
        if (accept) begin
          off_d  = req_addr_i[1:0];
          size_d = req_size_i;
          we_d   = req_we_i;
          uns_d  = req_unsigned_i;
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = RESP;
          end else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_we_d    = req_we_i ? st_we : 4'b0000;
            state_d     = BUS;
          end
        end
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_we_q     <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: RAM model on port B, reference memory and
// request-level expectation queues, directed cases plus randomized traffic.
module tb_lsu_mem_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        busy_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_rdata_i;

  lsu_mem_if #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .busy_o(busy_o), .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } mexp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rexp_t;

  mexp_t       memq[$];
  rexp_t       respq[$];
  logic [31:0] ram     [64];
  logic [31:0] ref_mem [64];
  logic        ram_rdy;
  logic        stray_rdy = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          n_mem = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;
  logic [3:0]  last_we = 4'h0;
  logic [31:0] last_wdata = 32'h0;
  int          last_cyc = 0;
  logic        prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM port B: completes one cycle after it sees valid; rdata is the addressed word.
  assign mem_rdata_i = ram[mem_addr_o[7:2]];
  assign mem_ready_i = ram_rdy | stray_rdy;
  always @(posedge clk or posedge rst) begin
    if (rst) ram_rdy <= 1'b0;
    else begin
      ram_rdy <= mem_valid_o && !ram_rdy;
      if (mem_valid_o && ram_rdy)
        for (int b = 0; b < 4; b++)
          if (mem_we_o[b]) ram[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  // Compare process: every cycle, check RAM-side and response-side outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      last_rdata = 32'h0;
      last_err   = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_done) chk("mem_gap", 32'(mem_valid_o), 32'h0);
      if (mem_valid_o) begin
        if (memq.size() == 0) chk("mem_unexpected", 32'(mem_valid_o), 32'h0);
        else begin
          chk("mem_addr", mem_addr_o, memq[0].addr);
          chk("mem_we", 32'(mem_we_o), 32'(memq[0].we));
          if (memq[0].we != 4'h0) chk("mem_wdata", mem_wdata_o, memq[0].wdata);
          last_we    = mem_we_o;
          last_wdata = mem_wdata_o;
          if (mem_ready_i) begin
            void'(memq.pop_front());
            n_mem++;
          end
        end
      end
      prev_done = mem_valid_o && mem_ready_i;
      if (resp_valid_o) begin
        if (respq.size() == 0) chk("resp_unexpected", 32'(resp_valid_o), 32'h0);
        else begin
          chk("resp_rdata", resp_rdata_o, respq[0].rdata);
          chk("resp_err", 32'(resp_err_o), 32'(respq[0].err));
          chk("resp_cycle", 32'(cyc), 32'(respq[0].due));
          void'(respq.pop_front());
        end
        last_rdata = resp_rdata_o;
        last_err   = resp_err_o;
        last_cyc   = cyc;
      end else begin
        chk("resp_hold_rdata", resp_rdata_o, last_rdata);
        chk("resp_hold_err", 32'(resp_err_o), 32'(last_err));
      end
    end
  end

  // Present a request from a negedge, wait for acceptance, and record what it must produce.
  task automatic send(input bit we, input bit [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] d);
    int          k = 0;
    int          off, nb;
    bit          err;
    logic [3:0]  be;
    logic [31:0] wd, w, mask32, v;
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
    req_unsigned_i = uns; req_addr_i = a; req_wdata_i = d;
    while (!req_ready_o && k < 20) begin @(negedge clk); k++; end
    if (!req_ready_o) begin
      chk("accept_timeout", 32'(req_ready_o), 32'h1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    off = int'(a[1:0]);
    nb  = 1 << sz;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    if (err) respq.push_back('{32'h0, 1'b1, cyc});
    else if (we) begin
      be = 4'(((1 << nb) - 1) << off);
      wd = (nb == 1) ? d[7:0] * 32'h01010101 : (nb == 2) ? d[15:0] * 32'h00010001 : d;
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
      memq.push_back('{a & ~32'h3, be, wd});
      respq.push_back('{32'h0, 1'b0, cyc + 2});
    end else begin
      w      = ref_mem[a[7:2]];
      mask32 = (nb == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * nb)) - 32'd1;
      v      = (w >> (8 * off)) & mask32;
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask32;
      memq.push_back('{a & ~32'h3, 4'h0, 32'h0});
      respq.push_back('{v, 1'b0, cyc + 2});
    end
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (k < 30 && (busy_o || respq.size() != 0 || memq.size() != 0)) begin
      @(negedge clk); k++;
    end
    chk("idle_timeout", 32'(busy_o || respq.size() != 0 || memq.size() != 0), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom; ref_mem[i] = ram[i];
    end
    ram[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'h0);
    chk("rst_resp_rdata", resp_rdata_o, 32'h0);
    chk("rst_resp_err", 32'(resp_err_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_mem_valid", 32'(mem_valid_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_we", 32'(mem_we_o), 32'h0);
    rst = 1'b0;
    // Stray RAM ready after reset must be ignored.
    @(negedge clk); stray_rdy = 1'b1;
    @(negedge clk); stray_rdy = 1'b0;
    chk("stray_busy", 32'(busy_o), 32'h0);
    chk("stray_resp", 32'(resp_valid_o), 32'h0);

    // Directed loads on word 0x10 = 0x8899AABB.
    send(0, 2'd2, 0, 32'h10, 0); wait_idle();
    chk("lw_10", last_rdata, 32'h8899AABB);
    chk("lw_10_err", 32'(last_err), 32'h0);
    chk("lw_10_latency", 32'(last_cyc - acc_cyc), 32'd2);
    send(0, 2'd0, 0, 32'h13, 0); wait_idle(); chk("lb_13", last_rdata, 32'hFFFFFF88);
    send(0, 2'd0, 1, 32'h13, 0); wait_idle(); chk("lbu_13", last_rdata, 32'h00000088);
    send(0, 2'd1, 0, 32'h12, 0); wait_idle(); chk("lh_12", last_rdata, 32'hFFFF8899);
    send(0, 2'd1, 0, 32'h10, 0); wait_idle(); chk("lh_10", last_rdata, 32'hFFFFAABB);

    // Byte store then word reload.
    send(1, 2'd0, 0, 32'h11, 32'h0000005A); wait_idle();
    chk("sb_we", 32'(last_we), 32'h2);
    chk("sb_wdata", last_wdata, 32'h5A5A5A5A);
    chk("sb_rdata", last_rdata, 32'h0);
    send(0, 2'd2, 0, 32'h10, 0); wait_idle(); chk("lw_after_sb", last_rdata, 32'h88995ABB);

    // Error requests make no RAM access.
    n0 = n_mem;
    send(0, 2'd1, 0, 32'h11, 0); wait_idle();
    chk("err_half_err", 32'(last_err), 32'h1); chk("err_half_rdata", last_rdata, 32'h0);
    send(1, 2'd2, 0, 32'h12, 32'hDEADBEEF); wait_idle();
    chk("err_word_err", 32'(last_err), 32'h1); chk("err_word_rdata", last_rdata, 32'h0);
    send(0, 2'd3, 0, 32'h10, 0); wait_idle();
    chk("err_size_err", 32'(last_err), 32'h1); chk("err_size_rdata", last_rdata, 32'h0);
    chk("err_no_mem", 32'(n_mem - n0), 32'h0);

    // Back-to-back requests with valid held high.
    n0 = n_mem;
    send(0, 2'd2, 0, 32'h10, 0);
    send(0, 2'd0, 1, 32'h20, 0);
    send(1, 2'd1, 0, 32'h22, 32'h1234C3D2);
    send(0, 2'd1, 1, 32'h22, 0);
    wait_idle();
    chk("b2b_accesses", 32'(n_mem - n0), 32'd4);
    chk("b2b_last", last_rdata, 32'h0000C3D2);

    // Reset while the access is on the bus.
    req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h10; req_unsigned_i = 1'b0;
    req_valid_i = 1'b1;
    memq.push_back('{32'h10, 4'h0, 32'h0});
    @(posedge clk); #1; req_valid_i = 1'b0;
    @(negedge clk);
    chk("rstbus_valid_before", 32'(mem_valid_o), 32'h1);
    rst = 1'b1; #1;
    chk("rstbus_valid_drop", 32'(mem_valid_o), 32'h0);
    chk("rstbus_busy", 32'(busy_o), 32'h0);
    @(negedge clk); rst = 1'b0; memq.delete(); respq.delete();
    stray_rdy = 1'b1;
    @(negedge clk); stray_rdy = 1'b0;
    chk("rstbus_no_resp", 32'(resp_valid_o), 32'h0);
    @(negedge clk);
    chk("rstbus_no_resp2", 32'(resp_valid_o), 32'h0);
    send(0, 2'd2, 0, 32'h10, 0); wait_idle();
    chk("rstbus_next", last_rdata, 32'h88995ABB);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      bit          we, uns;
      bit [1:0]    sz;
      logic [31:0] a;
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = 32'($urandom_range(0, 255));
      if (sz != 2'd0 && $urandom_range(0, 3) != 0) a = a & ~((sz == 2'd1) ? 32'h1 : 32'h3);
      send(we, sz, uns, a, $urandom);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
